// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-wide 7-segment driver with scan prescaler and a double-buffered display register.
// Optional leading-zero blanking is compiled in when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int HEX_MODE     = 0,
    parameter int COMMON_ANODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  blank,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = 5 * DIGITS;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     prescaler;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     pending;
    logic [BW-1:0]     active;
    logic [BW-1:0]     load_word;
    logic [7:0]        seg_r;
    logic [DIGITS-1:0] dig_r;
    logic              fs_r;
    logic              tick;
    logic              frame_end;

    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] act_dp;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic [6:0]        cur_dec;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] d;
        d = 7'h00;
        case (n)
            4'h0: d = 7'h3F;
            4'h1: d = 7'h06;
            4'h2: d = 7'h5B;
            4'h3: d = 7'h4F;
            4'h4: d = 7'h66;
            4'h5: d = 7'h6D;
            4'h6: d = 7'h7D;
            4'h7: d = 7'h07;
            4'h8: d = 7'h7F;
            4'h9: d = 7'h6F;
            4'hA: d = (HEX_MODE != 0) ? 7'h77 : 7'h00;
            4'hB: d = (HEX_MODE != 0) ? 7'h7C : 7'h00;
            4'hC: d = (HEX_MODE != 0) ? 7'h39 : 7'h00;
            4'hD: d = (HEX_MODE != 0) ? 7'h5E : 7'h00;
            4'hE: d = (HEX_MODE != 0) ? 7'h79 : 7'h00;
            4'hF: d = (HEX_MODE != 0) ? 7'h71 : 7'h00;
            default: d = 7'h00;
        endcase
        return d;
    endfunction

    assign load_word = {dp_in, data_in};
    assign tick      = (prescaler == PRE_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
            fs_r      <= 1'b0;
        end else if (!en) begin
            prescaler <= '0;
            idx       <= '0;
            fs_r      <= 1'b0;
        end else begin
            fs_r <= frame_end;
            if (tick) begin
                prescaler <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // While disabled the active buffer tracks pending so re-enabling shows fresh data at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (load) begin
                pending <= load_word;
            end
            if (!en) begin
                active <= pending;
            end else if (frame_end) begin
                active <= load ? load_word : pending;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            nib[k] = active[4*k +: 4];
        end
    end

    assign act_dp  = active[BW-1 -: DIGITS];
    assign cur_nib = nib[idx];
    assign cur_dp  = act_dp[idx];

`ifdef SEG7_SCAN_LZB_EN
    // lz[k]: nibble k and every more-significant nibble are zero; digit 0 is never blanked.
    logic [DIGITS-1:0] lz;

    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run   = run && (nib[k] == 4'h0);
            lz[k] = run;
        end
    end

    assign cur_dec = lz[idx] ? 7'h00 : decode(cur_nib);
`else
    assign cur_dec = decode(cur_nib);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= 8'h00;
            dig_r <= '0;
        end else if (en && !blank) begin
            seg_r <= {cur_dp, cur_dec};
            dig_r <= DIGITS'(1) << idx;
        end else begin
            seg_r <= 8'h00;
            dig_r <= '0;
        end
    end

    assign seg         = (COMMON_ANODE != 0) ? ~seg_r : seg_r;
    assign dig_sel     = (COMMON_ANODE != 0) ? ~dig_r : dig_r;
    assign frame_start = fs_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a common-cathode decimal instance and a common-anode hex instance share stimulus.
// Expected display slots are queued by the stimulus; a negedge monitor pops one per dig_sel change.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        blank;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [7:0]  seg_a;
    logic [3:0]  dig_a;
    logic        fs_a;
    logic [7:0]  seg_b;
    logic [3:0]  dig_b;
    logic        fs_b;

`ifdef SEG7_SCAN_LZB_EN
    localparam logic [7:0] Z = 8'h00;
`else
    localparam logic [7:0] Z = 8'h3F;
`endif

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .COMMON_ANODE(0)) u_dec (
        .clk(clk), .rst_n(rst_n), .en(en), .blank(blank), .load(load),
        .data_in(data_in), .dp_in(dp_in),
        .seg(seg_a), .dig_sel(dig_a), .frame_start(fs_a)
    );

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1), .COMMON_ANODE(1)) u_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .blank(blank), .load(load),
        .data_in(data_in), .dp_in(dp_in),
        .seg(seg_b), .dig_sel(dig_b), .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dig;
        logic [7:0] seg;
        logic [7:0] segh;
        int         fs_at;
        int         len;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) if (rst_n) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_e(input logic [3:0] dig, input logic [7:0] s, input logic [7:0] sh,
                          input int fs_at, input int len);
        exp_t e;
        e.dig = dig; e.seg = s; e.segh = sh; e.fs_at = fs_at; e.len = len;
        q.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [7:0] h2, input logic [7:0] h3);
        push_e(4'b0001, s0, s0, -1, 4);
        push_e(4'b0010, s1, s1, -1, 4);
        push_e(4'b0100, s2, h2, -1, 4);
        push_e(4'b1000, s3, h3, 3, 4);
    endtask

    task automatic at_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: a change of dig_sel marks the start of the next expected display segment.
    exp_t       cur;
    bit         have_cur = 1'b0;
    bit         first = 1'b1;
    int         held = 0;
    logic [3:0] prev_dig = 4'h0;

    always @(negedge clk) begin
        logic [7:0] inv_seg;
        logic [3:0] inv_dig;
        if (mon_en) begin
            if (first || dig_a !== prev_dig) begin
                if (have_cur && cur.len != 0) chk("slot_len", held, cur.len);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL underflow: dig_sel=%0h with no expected entry at t=%0t", dig_a, $time);
                    have_cur = 1'b0;
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                end
                held = 0;
                first = 1'b0;
            end
            if (have_cur) begin
                inv_seg = ~cur.segh;
                inv_dig = ~cur.dig;
                chk("dig_sel", dig_a, cur.dig);
                chk("seg", seg_a, cur.seg);
                chk("hex_dig_pins", dig_b, inv_dig);
                chk("hex_seg_pins", seg_b, inv_seg);
                chk("frame_start", fs_a, (held == cur.fs_at) ? 1 : 0);
                chk("hex_frame_start", fs_b, (held == cur.fs_at) ? 1 : 0);
            end
            held++;
            prev_dig = dig_a;
        end
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; blank = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
        push_e(4'b0000, 8'h00, 8'h00, -1, 0);
        repeat (3) push_frame(8'h3F, Z, Z, Z, Z, Z);
        #1 mon_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Mid-frame load: current frame finishes with the old value.
        at_edge(37);
        load = 1'b1; data_in = 16'h1234; dp_in = 4'b0010;
        push_frame(8'h66, 8'hCF, 8'h5B, 8'h06, 8'h5B, 8'h06);
        at_edge(38);
        load = 1'b0;

        at_edge(53);
        load = 1'b1; data_in = 16'hFA98; dp_in = 4'b0000;
        push_frame(8'h7F, 8'h6F, 8'h00, 8'h00, 8'h77, 8'h71);
        push_e(4'b0001, 8'h7F, 8'h7F, -1, 4);
        push_e(4'b0010, 8'h6F, 8'h6F, -1, 1);
        push_e(4'b0000, 8'h00, 8'h00, -1, 6);
        push_e(4'b0100, 8'h00, 8'h77, -1, 1);
        push_e(4'b1000, 8'h00, 8'h71, 3, 4);
        push_e(4'b0001, 8'h7F, 8'h7F, -1, 4);
        push_e(4'b0010, 8'h6F, 8'h6F, -1, 2);
        at_edge(54);
        load = 1'b0;

        at_edge(85);
        blank = 1'b1;
        at_edge(91);
        blank = 1'b0;

        at_edge(97);
        load = 1'b1; data_in = 16'h0005; dp_in = 4'b0000;
        push_e(4'b0000, 8'h00, 8'h00, -1, 3);
        repeat (2) push_frame(8'h6D, Z, Z, Z, Z, Z);
        at_edge(98);
        load = 1'b0;

        at_edge(102);
        en = 1'b0;
        at_edge(105);
        en = 1'b1;

        // Load lands on the end-of-frame tick edge.
        at_edge(136);
        load = 1'b1; data_in = 16'h9999; dp_in = 4'b0000;
        repeat (2) push_frame(8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F);
        at_edge(137);
        load = 1'b0;

        at_edge(155);
        load = 1'b1; data_in = 16'h0040; dp_in = 4'b0000;
        push_frame(8'h3F, 8'h66, Z, Z, Z, Z);
        at_edge(156);
        load = 1'b0;

        at_edge(171);
        load = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
        push_e(4'b0001, 8'h3F, 8'h3F, -1, 4);
        push_e(4'b0010, Z, Z, -1, 4);
        at_edge(172);
        load = 1'b0;

        // Pending 1234 must be lost by the asynchronous reset below.
        at_edge(189);
        load = 1'b1; data_in = 16'h1234; dp_in = 4'b1111;
        push_e(4'b0100, Z, Z, -1, 1);
        push_e(4'b0000, 8'h00, 8'h00, -1, 0);
        repeat (2) push_frame(8'h3F, Z, Z, Z, Z, Z);
        at_edge(190);
        load = 1'b0;

        at_edge(195);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (32) @(posedge clk);
        #6 mon_en = 1'b0;

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
